// File: rtl/mul_iter.sv
// Iterative radix-2 shift-add multiplier: signed or unsigned WIDTH x WIDTH -> 2*WIDTH product
// over WIDTH+2 cycles, with a start/busy/done handshake and product registers held until the next result.
module mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             n_flag,
    output logic             z_flag
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t               state_r;
    logic [2*WIDTH-1:0]   mcand_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic [WIDTH-1:0]     mplier_r;
    logic [CNT_W-1:0]     cnt_r;
    logic                 sign_r;

    logic [WIDTH-1:0]     a_mag_s;
    logic [WIDTH-1:0]     b_mag_s;
    logic                 sign_s;
    logic [2*WIDTH-1:0]   step_s;
    logic [2*WIDTH-1:0]   fix_val_s;

    // The most-negative operand negates to itself, which is exactly its unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
        magnitude = (is_signed && v[WIDTH-1]) ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    // Operand magnitudes, one shift-add step and the sign-corrected final value.
    always_comb begin
        a_mag_s   = magnitude(a, op_signed);
        b_mag_s   = magnitude(b, op_signed);
        sign_s    = op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
        step_s    = mplier_r[0] ? (acc_r + mcand_r) : acc_r;
        fix_val_s = sign_r ? (~acc_r + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc_r;
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            mcand_r   <= {(2*WIDTH){1'b0}};
            acc_r     <= {(2*WIDTH){1'b0}};
            mplier_r  <= {WIDTH{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            sign_r    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result_lo <= {WIDTH{1'b0}};
            result_hi <= {WIDTH{1'b0}};
            n_flag    <= 1'b0;
            z_flag    <= 1'b1;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand_r  <= {{WIDTH{1'b0}}, a_mag_s};
                        mplier_r <= b_mag_s;
                        sign_r   <= sign_s;
                        acc_r    <= {(2*WIDTH){1'b0}};
                        cnt_r    <= {CNT_W{1'b0}};
                        busy     <= 1'b1;
                        state_r  <= RUN;
                    end else begin
                        busy     <= 1'b0;
                        state_r  <= IDLE;
                    end
                end
                RUN: begin
                    acc_r    <= step_s;
                    mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
                    mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
                    cnt_r    <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_r == CNT_W'(WIDTH - 1)) begin
                        state_r <= FIX;
                    end else begin
                        state_r <= RUN;
                    end
                end
                FIX: begin
                    result_hi <= fix_val_s[2*WIDTH-1:WIDTH];
                    result_lo <= fix_val_s[WIDTH-1:0];
                    n_flag    <= fix_val_s[2*WIDTH-1];
                    z_flag    <= ~|fix_val_s;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    state_r   <= DONE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_iter.sv
// Directed self-checking bench for mul_iter: products, flags, latency, held results,
// ignored start, back-to-back operation and mid-operation reset.
module tb_mul_iter;

    logic        clk;
    logic        reset;
    logic        start;
    logic        op_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result_lo;
    logic [31:0] result_hi;
    logic        n_flag;
    logic        z_flag;

    int          n_checks;
    int          n_fail;
    logic [63:0] prev_prod;

    mul_iter #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op_signed (op_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result_lo (result_lo),
        .result_hi (result_hi),
        .n_flag    (n_flag),
        .z_flag    (z_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, {63'd0, busy}, 64'd0);
        check({tag, "_done"}, {63'd0, done}, 64'd0);
        check({tag, "_result"}, {result_hi, result_lo}, 64'd0);
        check({tag, "_n"}, {63'd0, n_flag}, 64'd0);
        check({tag, "_z"}, {63'd0, z_flag}, 64'd1);
    endtask

    // Called #1 after a clock edge; returns #1 after the edge on which done rises.
    task automatic run_op(input string tag, input logic sgn, input logic [31:0] aa,
                          input logic [31:0] bb, input logic [63:0] exp, input int inj);
        int cyc;
        start     = 1'b1;
        op_signed = sgn;
        a         = aa;
        b         = bb;
        @(posedge clk);
        #1;
        start     = 1'b0;
        op_signed = ~sgn;
        a         = $urandom;
        b         = $urandom;
        cyc       = 1;
        while (done !== 1'b1 && cyc < 60) begin
            check({tag, "_busy_run"}, {63'd0, busy}, 64'd1);
            check({tag, "_hold"}, {result_hi, result_lo}, prev_prod);
            if (cyc == inj) begin
                start = 1'b1;
                a     = 32'd5;
                b     = 32'd5;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        check({tag, "_latency"}, 64'(cyc), 64'd34);
        check({tag, "_busy_done"}, {63'd0, busy}, 64'd0);
        check({tag, "_product"}, {result_hi, result_lo}, exp);
        check({tag, "_n"}, {63'd0, n_flag}, {63'd0, exp[63]});
        check({tag, "_z"}, {63'd0, z_flag}, (exp == 64'd0) ? 64'd1 : 64'd0);
        prev_prod = exp;
    endtask

    task automatic idle_gap(input string tag);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
        check({tag, "_busy_idle"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        int extra;
        clk       = 1'b0;
        reset     = 1'b0;
        start     = 1'b0;
        op_signed = 1'b0;
        a         = 32'd0;
        b         = 32'd0;
        n_checks  = 0;
        n_fail    = 0;
        prev_prod = 64'd0;

        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        reset = 1'b1;
        @(posedge clk);
        #1;

        run_op("umax", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0);
        idle_gap("umax");
        run_op("s7xm3", 1'b1, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 0);
        idle_gap("s7xm3");
        run_op("smin2", 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 0);
        idle_gap("smin2");
        run_op("sm1m1", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 0);
        idle_gap("sm1m1");
        run_op("zero_u", 1'b0, 32'd0, 32'h1234_5678, 64'd0, 0);
        idle_gap("zero_u");
        run_op("u_m1x2", 1'b0, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE, 0);
        idle_gap("u_m1x2");
        run_op("zero_s", 1'b1, 32'd0, 32'h1234_5678, 64'd0, 0);
        idle_gap("zero_s");
        run_op("s_m1x2", 1'b1, 32'hFFFF_FFFF, 32'd2, 64'hFFFF_FFFF_FFFF_FFFE, 0);
        idle_gap("s_m1x2");
        run_op("s_minx1", 1'b1, 32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000, 0);
        idle_gap("s_minx1");

        // A start pulse in RUN cycle 10 must be neither honoured nor queued.
        run_op("inject", 1'b0, 32'h1234_5678, 32'h0000_0010, 64'h0000_0001_2345_6780, 10);
        extra = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) extra++;
        end
        check("inject_single_done", 64'(extra), 64'd0);
        check("inject_idle_busy", {63'd0, busy}, 64'd0);

        // Second start issued during DONE: its done lands 34 cycles after the first.
        run_op("b2b_first", 1'b0, 32'd3, 32'd4, 64'd12, 0);
        run_op("b2b_second", 1'b1, 32'hFFFF_FFFE, 32'd5, 64'hFFFF_FFFF_FFFF_FFF6, 0);
        idle_gap("b2b");

        // Reset pulse in RUN cycle 15 discards the operation.
        start     = 1'b1;
        op_signed = 1'b0;
        a         = 32'd9;
        b         = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (14) begin
            @(posedge clk);
            #1;
        end
        check("midrst_busy_before", {63'd0, busy}, 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check_idle_outputs("midrst_now");
        @(posedge clk);
        #1;
        reset = 1'b1;
        check_idle_outputs("midrst_held");
        prev_prod = 64'd0;
        extra = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) extra++;
        end
        check("midrst_no_done", 64'(extra), 64'd0);
        run_op("after_rst", 1'b0, 32'd6, 32'd7, 64'd42, 0);
        idle_gap("after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_iter.md
# mul_iter

Iterative shift-add multiplier for the multicycle ARM core. It sits in the datapath beside the ALU and is driven by the control unit when a multiply instruction (Op = 2'b11) is decoded. It computes a full 2·WIDTH-bit signed or unsigned product over WIDTH+2 cycles using a start/busy/done handshake. The product and its N/Z flags stay registered until the next accepted start, so the controller's write-back state can read them at any later cycle.

## Interface
- WIDTH, 32, operand width; product is 2·WIDTH bits.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low (0 = reset).
- start  in  1  request; sampled only in IDLE or DONE.
- op_signed  in  1  1 = two's-complement operands (SMULL), 0 = unsigned (UMULL/MUL); sampled with start.
- a  in  WIDTH  multiplicand; sampled with start.
- b  in  WIDTH  multiplier; sampled with start.
- busy  out  1  high in RUN and FIX.
- done  out  1  one-cycle pulse in DONE.
- result_lo  out  WIDTH  product bits [WIDTH-1:0].
- result_hi  out  WIDTH  product bits [2·WIDTH-1:WIDTH].
- n_flag  out  1  product bit 2·WIDTH-1.
- z_flag  out  1  1 when the full 2·WIDTH-bit product is zero.

## Operation
- **States and transitions:**
  - IDLE goes to RUN on start.
  - RUN lasts exactly WIDTH cycles, then goes to FIX.
  - FIX goes to DONE.
  - DONE goes to RUN if start is high, otherwise to IDLE.
- **Accept, on the start edge:**
  - Latch |a| and |b|. Magnitudes are used only when op_signed=1; otherwise the raw operands are latched.
  - Latch sign = op_signed & (a[WIDTH-1] ^ b[WIDTH-1]).
  - Clear the internal accumulator and the step counter.
- **RUN step:** each cycle performs one radix-2 step on the unsigned magnitudes.
  - If the current multiplier bit is 1, add the multiplicand, aligned to that bit, into the accumulator.
  - Advance to the next multiplier bit.
  - The accumulator is 2·WIDTH bits, with carry out of the add kept (no truncation).
- **FIX:**
  - Output value = sign ? two's-complement negate of the accumulator : accumulator.
  - Write it to result_hi/result_lo, n_flag and z_flag on the FIX→DONE edge.
  - Output registers change only on this edge.
- **Most-negative operand:** |0x8000_0000| = 0x8000_0000 must be handled as an unsigned magnitude; no overflow case exists.
- **Stable outputs:** during RUN and FIX, result_* and the flags keep showing the previous product.
- **Ignored inputs:**
  - start in RUN or FIX has no effect and is not queued.
  - Operand changes after acceptance have no effect.
- **Reset, asserted at any time including mid-operation:**
  - Forces IDLE; the in-flight operation is discarded with no done.
  - busy=0, done=0, result_lo=result_hi=0, n_flag=0, z_flag=1 (consistent with a zero product); accumulator and counter are cleared.

## Timing
- Start high in cycle 0 (sampled at the end of cycle 0).
- Cycles 1..WIDTH are RUN, with busy=1.
- Cycle WIDTH+1 is FIX, with busy=1.
- Cycle WIDTH+2 is DONE: done=1, busy=0, new result and flags valid.
- Latency from start to done = WIDTH+2 cycles (34 for WIDTH=32). It is fixed and independent of operand values.
- Back-to-back: start high during DONE is accepted. The next done comes WIDTH+2 cycles later, and result stays valid until that FIX edge.
- done is never high for two consecutive cycles unless WIDTH+2 = 1 (impossible); busy and done are never high together.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Unsigned max:** op_signed=0, a=b=0xFFFF_FFFF.
  - result_hi=0xFFFF_FFFE, result_lo=0x0000_0001, n=1, z=0.
  - done exactly 34 cycles after start.
- **Signed mixed sign:** op_signed=1, a=7, b=0xFFFF_FFFD (−3).
  - Product 0xFFFF_FFFF_FFFF_FFEB, n=1, z=0.
- **Signed corner cases:**
  - a=b=0x8000_0000 gives 0x4000_0000_0000_0000, n=0.
  - a=b=0xFFFF_FFFF (−1) gives 0x0000_0000_0000_0001.
- **Zero and flags:** a=0, b=0x1234_5678, either mode.
  - Product 0, z=1, n=0.
  - The previous result stays visible throughout RUN/FIX until the FIX→DONE edge.
- **Handshake:**
  - start pulsed again at cycle 10 of RUN with new operands: ignored; the first product is correct and only one done occurs.
  - start held high in DONE: second operation runs immediately, and its done comes 34 cycles after the first done.
- **Reset mid-operation:** reset=0 for one cycle at RUN cycle 15.
  - Outputs immediately busy=0, done=0, result=0, z=1.
  - No done follows; a subsequent start completes normally.
